// File: rtl/alu_acc_stage.sv
// alu_acc_stage: accumulator/sequencer stage around an external add/sub ALU.
//
// Accepts one operation per op_valid/op_ready handshake and registers the opcode
// and operand. During the single EXEC cycle it drives the ALU: the accumulator
// feeds back as operand a. At the end of EXEC it captures the result into acc
// and updates the flags. The result is then held on res_valid until res_ready.
//
// Optional feature: define ALU_ACC_OVF_EN to build the signed-overflow flag
// (flag_v). Without the macro, flag_v is tied to 0.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   op_valid/op_ready    upstream handshake; op_code (00 LOAD, 01 ADD, 10 SUB,
//                        11 CLEAR), op_data (operand / load value)
//   alu_s, alu_a, alu_b  ALU drive: subtract select, acc, registered operand
//   alu_out, alu_carry   ALU result and carry-out (1 = no borrow on SUB)
//   acc, flag_c/z/n/v    accumulator and condition flags
//   res_valid/res_ready  downstream handshake
module alu_acc_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic             alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpAdd   = 2'b01;
    localparam logic [1:0] OpSub   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] acc_q;
    logic             flag_c_q;
    logic             flag_z_q;
    logic             flag_n_q;

    logic [WIDTH-1:0] acc_d;
    logic             carry_d;

    // Next accumulator and carry, valid while in EXEC (ALU has settled).
    always_comb begin
        acc_d   = '0;
        carry_d = 1'b0;
        unique case (op_q)
            OpLoad:       acc_d = op_b_q;
            OpAdd, OpSub: begin
                acc_d   = alu_out;
                carry_d = alu_carry;
            end
            OpClear:      acc_d = '0;
            default:      acc_d = '0;
        endcase
    end

`ifdef ALU_ACC_OVF_EN
    logic flag_v_q;
    logic ovf_d;
    logic a_msb;
    logic b_msb;
    logic r_msb;

    assign a_msb = acc_q[WIDTH-1];
    assign b_msb = op_b_q[WIDTH-1];
    assign r_msb = alu_out[WIDTH-1];

    // Two's-complement overflow on the operation as seen by the user
    // (b, not ~b, for subtract).
    always_comb begin
        ovf_d = 1'b0;
        unique case (op_q)
            OpAdd:   ovf_d = (a_msb == b_msb) && (r_msb != a_msb);
            OpSub:   ovf_d = (a_msb != b_msb) && (r_msb != a_msb);
            default: ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_v_q <= 1'b0;
        end else if (state_q == StExec) begin
            flag_v_q <= ovf_d;
        end
    end

    assign flag_v = flag_v_q;
`else
    assign flag_v = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpLoad;
            op_b_q   <= '0;
            acc_q    <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (op_valid) begin
                        op_q    <= op_code;
                        op_b_q  <= op_data;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    acc_q    <= acc_d;
                    flag_c_q <= carry_d;
                    flag_z_q <= (acc_d == '0);
                    flag_n_q <= acc_d[WIDTH-1];
                    state_q  <= StResp;
                end
                StResp: begin
                    if (res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // All outputs are straight decodes of registers, so they are glitch-free
    // and stable for the whole of EXEC.
    assign op_ready  = (state_q == StIdle);
    assign res_valid = (state_q == StResp);
    assign alu_a     = acc_q;
    assign alu_b     = op_b_q;
    assign alu_s     = (op_q == OpSub);
    assign acc       = acc_q;
    assign flag_c    = flag_c_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_alu_acc_stage.sv
module tb_alu_acc_stage;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] SUB   = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

`ifdef ALU_ACC_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] op_code = 2'b00;
    logic [3:0] op_data = 4'h0;
    logic       alu_s;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_out;
    logic       alu_carry;
    logic [3:0] acc;
    logic       flag_c, flag_z, flag_n, flag_v;
    logic       res_valid;
    logic       res_ready = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_acc_stage #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_data   (op_data),
        .alu_s     (alu_s),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    // External 4-bit ALU: a + b, or a + ~b + 1 when subtracting.
    logic [4:0] alu_sum;
    assign alu_sum = {1'b0, alu_a} + {1'b0, (alu_s ? ~alu_b : alu_b)} + {4'b0, alu_s};
    assign alu_out   = alu_sum[3:0];
    assign alu_carry = alu_sum[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0] acc;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } res_t;

    // Result of one operation computed with plain integer arithmetic.
    function automatic res_t apply(input logic [1:0] code, input logic [3:0] d,
                                   input logic [3:0] a);
        res_t r;
        int ua, ud, sa, sd, sr;
        r  = '0;
        ua = int'(a);
        ud = int'(d);
        sa = a[3] ? ua - 16 : ua;
        sd = d[3] ? ud - 16 : ud;
        case (code)
            LOAD: r.acc = d;
            ADD: begin
                r.acc = 4'(ua + ud);
                r.c   = (ua + ud) > 15;
                sr    = sa + sd;
                r.v   = (sr > 7) || (sr < -8);
            end
            SUB: begin
                r.acc = 4'(ua - ud);
                r.c   = (ua >= ud);
                sr    = sa - sd;
                r.v   = (sr > 7) || (sr < -8);
            end
            default: r.acc = 4'h0;
        endcase
        r.z = (r.acc == 4'h0);
        r.n = r.acc[3];
        if (!OvfEn) r.v = 1'b0;
        return r;
    endfunction

    logic       m_busy = 1'b0;   // an op is in flight (accepted, not yet handed off)
    logic       m_exec = 1'b0;   // op accepted on the previous edge
    logic       m_rv   = 1'b0;   // result is being offered downstream
    res_t       m_st   = '0;     // architecturally visible acc/flags
    res_t       m_p    = '0;     // pending result of the in-flight op
    logic [1:0] m_pcode = 2'b00;
    logic [3:0] m_pdata = 4'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_exec  <= 1'b0;
            m_rv    <= 1'b0;
            m_st    <= '0;
            m_p     <= '0;
            m_pcode <= 2'b00;
            m_pdata <= 4'h0;
        end else if (!m_busy && op_valid) begin
            m_busy  <= 1'b1;
            m_exec  <= 1'b1;
            m_p     <= apply(op_code, op_data, m_st.acc);
            m_pcode <= op_code;
            m_pdata <= op_data;
        end else if (m_exec) begin
            m_exec <= 1'b0;
            m_st   <= m_p;
            m_rv   <= 1'b1;
        end else if (m_rv && res_ready) begin
            m_rv   <= 1'b0;
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("op_ready", 32'(op_ready), 32'(!m_busy));
        check("res_valid", 32'(res_valid), 32'(m_rv));
        check("acc", 32'(acc), 32'(m_st.acc));
        check("flag_c", 32'(flag_c), 32'(m_st.c));
        check("flag_z", 32'(flag_z), 32'(m_st.z));
        check("flag_n", 32'(flag_n), 32'(m_st.n));
        check("flag_v", 32'(flag_v), 32'(m_st.v));
        if (m_exec) begin
            check("alu_a", 32'(alu_a), 32'(m_st.acc));
            check("alu_b", 32'(alu_b), 32'(m_pdata));
            check("alu_s", 32'(alu_s), 32'(m_pcode == SUB));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [1:0] c, input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = c;
        op_data  = d;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) check("send_timeout", 32'(op_ready), 32'd1);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) check("idle_timeout", 32'(op_ready), 32'd1);
    endtask

    task automatic check_res(input string name, input logic [3:0] a,
                             input logic c, input logic z, input logic n, input logic v);
        check({name, "_acc"}, 32'(acc), 32'(a));
        check({name, "_c"}, 32'(flag_c), 32'(c));
        check({name, "_z"}, 32'(flag_z), 32'(z));
        check({name, "_n"}, 32'(flag_n), 32'(n));
        check({name, "_v"}, 32'(flag_v), 32'(v));
    endtask

    initial begin
        int n;

        // 1: reset with an op pending, then first-op latency.
        op_valid = 1'b1;
        op_code  = LOAD;
        op_data  = 4'b0101;
        repeat (3) @(negedge clk);
        check("rst_op_ready", 32'(op_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check_res("rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_alu_s", 32'(alu_s), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        check("lat_exec_rv", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("lat_resp_rv", 32'(res_valid), 32'd1);
        check("lat_acc", 32'(acc), 32'h5);
        wait_idle();

        // 2: LOAD 0011, ADD 0101.
        send(LOAD, 4'b0011);
        send(ADD, 4'b0101);
        wait_idle();
        check_res("t2", 4'b1000, 1'b0, 1'b0, 1'b1, OvfEn);

        // 3: LOAD 1111, ADD 0001.
        send(LOAD, 4'b1111);
        send(ADD, 4'b0001);
        wait_idle();
        check_res("t3", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);

        // 4: subtraction without and with borrow.
        send(LOAD, 4'b1010);
        send(SUB, 4'b0011);
        wait_idle();
        check_res("t4a", 4'b0111, 1'b1, 1'b0, 1'b0, OvfEn);
        send(LOAD, 4'b0010);
        send(SUB, 4'b0100);
        wait_idle();
        check_res("t4b", 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0);
        send(CLEAR, 4'b1001);
        wait_idle();
        check_res("t4c", 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        send(LOAD, 4'b1110);
        wait_idle();

        // 5: downstream stall with op_valid held high.
        res_ready = 1'b0;
        send(ADD, 4'b0001);
        n = 0;
        while (!res_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_rv_seen", 32'(res_valid), 32'd1);
        op_valid = 1'b1;
        op_code  = LOAD;
        op_data  = 4'b1001;
        repeat (4) begin
            @(negedge clk);
            check("t5_stall_ready", 32'(op_ready), 32'd0);
            check("t5_stall_rv", 32'(res_valid), 32'd1);
            check("t5_stall_acc", 32'(acc), 32'hf);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t5_release_ready", 32'(op_ready), 32'd1);
        check("t5_release_rv", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("t5_accept_ready", 32'(op_ready), 32'd0);
        op_valid = 1'b0;
        wait_idle();
        check("t5_acc", 32'(acc), 32'h9);

        // 6: reset during EXEC.
        send(LOAD, 4'b0111);
        wait_idle();
        send(ADD, 4'b0001);
        check("t6_exec_alu_a", 32'(alu_a), 32'h7);
        check("t6_exec_alu_b", 32'(alu_b), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_res("t6_rst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_rst_ready", 32'(op_ready), 32'd1);
        check("t6_rst_alu_s", 32'(alu_s), 32'd0);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("t6_no_rv", 32'(res_valid), 32'd0);
            check("t6_alu_s", 32'(alu_s), 32'd0);
        end

        // Recovery after reset: 0 - 3 wraps with borrow.
        send(SUB, 4'b0011);
        wait_idle();
        check_res("post", 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
